// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared encodings and helper functions for the data-memory responder
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_WAIT = 2'b01;
    localparam logic [1:0] ST_RESP = 2'b10;

    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << off;
            SZ_HALF: be = off[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Word index is compared at full width so addresses far above the array never alias into it.
    function automatic logic access_err(input logic [1:0] size, input logic [31:0] addr,
                                        input int unsigned depth);
        logic err;
        err = ({2'b00, addr[31:2]} >= depth);
        case (size)
            SZ_HALF: err = err | addr[0];
            SZ_WORD: err = err | (addr[1:0] != 2'b00);
            SZ_ILL:  err = 1'b1;
            default: ;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - word-addressed storage with byte write enables and a registered read port
module dmem_array #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          en,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    // Contents are deliberately left unreset so this can be replaced by an SRAM macro.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
            rdata_q <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - single-outstanding load/store target with programmable response latency
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(LATENCY + 1);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          we_q, we_d;
    logic [31:0]   addr_q, addr_d;
    logic [1:0]    size_q, size_d;
    logic [31:0]   wdata_q, wdata_d;

    logic          accept;
    logic          go_resp;
    logic          cur_we;
    logic [31:0]   cur_addr;
    logic [1:0]    cur_size;
    logic [31:0]   cur_wdata;
    logic          cur_err;
    logic          rsp_err_w;
    logic [3:0]    arr_be;
    logic [31:0]   arr_wdata;
    logic [31:0]   arr_rdata;
    logic [31:0]   load_shift;
    logic [31:0]   load_data;

    assign req_ready = reset && (state_q == ST_IDLE);
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (state_q == ST_RESP);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        size_d  = size_q;
        wdata_d = wdata_q;
        go_resp = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    size_d  = req_size;
                    wdata_d = req_wdata;
                    if (LATENCY > 1) begin
                        state_d = ST_WAIT;
                        cnt_d   = CW'(LATENCY - 1);
                    end else begin
                        state_d = ST_RESP;
                        go_resp = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = ST_RESP;
                    go_resp = 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            size_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            wdata_q <= wdata_d;
        end
    end

    // With LATENCY=1 the array is accessed on the acceptance edge itself, before capture.
    assign cur_we    = (state_q == ST_IDLE) ? req_we    : we_q;
    assign cur_addr  = (state_q == ST_IDLE) ? req_addr  : addr_q;
    assign cur_size  = (state_q == ST_IDLE) ? req_size  : size_q;
    assign cur_wdata = (state_q == ST_IDLE) ? req_wdata : wdata_q;
    assign cur_err   = access_err(cur_size, cur_addr, DEPTH);

    assign arr_be    = (go_resp && cur_we && !cur_err) ? byte_en(cur_size, cur_addr[1:0]) : 4'b0000;
    assign arr_wdata = cur_wdata << {cur_addr[1:0], 3'b000};

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .en    (go_resp),
        .be    (arr_be),
        .addr  (cur_addr[AW+1:2]),
        .wdata (arr_wdata),
        .rdata (arr_rdata)
    );

    assign rsp_err_w  = access_err(size_q, addr_q, DEPTH);
    assign load_shift = arr_rdata >> {addr_q[1:0], 3'b000};

    always_comb begin
        load_data = 32'h0;
        case (size_q)
            SZ_BYTE: load_data = {24'h0, load_shift[7:0]};
            SZ_HALF: load_data = {16'h0, load_shift[15:0]};
            SZ_WORD: load_data = load_shift;
            default: load_data = 32'h0;
        endcase
    end

    assign rsp_rdata = (rsp_valid && !we_q && !rsp_err_w) ? load_data : 32'h0;
    assign rsp_err   = rsp_valid && rsp_err_w;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder
module tb_dmem_responder;

    localparam int DEPTH = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        sel;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic [31:0] req_wdata;
    logic        rsp_ready;

    logic        a_req_valid, a_req_ready, a_rsp_valid, a_rsp_ready, a_rsp_err;
    logic [31:0] a_rsp_rdata;
    logic        b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready, b_rsp_err;
    logic [31:0] b_rsp_rdata;

    logic        cur_req_ready, cur_rsp_valid, cur_rsp_err;
    logic [31:0] cur_rsp_rdata;

    assign a_req_valid = req_valid & ~sel;
    assign b_req_valid = req_valid & sel;
    assign a_rsp_ready = rsp_ready & ~sel;
    assign b_rsp_ready = 1'b1;

    assign cur_req_ready = sel ? b_req_ready : a_req_ready;
    assign cur_rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
    assign cur_rsp_err   = sel ? b_rsp_err   : a_rsp_err;
    assign cur_rsp_rdata = sel ? b_rsp_rdata : a_rsp_rdata;

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(2)) u_dut_l2 (
        .clk       (clk),
        .reset     (reset),
        .req_valid (a_req_valid),
        .req_ready (a_req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_size  (req_size),
        .req_wdata (req_wdata),
        .rsp_valid (a_rsp_valid),
        .rsp_ready (a_rsp_ready),
        .rsp_rdata (a_rsp_rdata),
        .rsp_err   (a_rsp_err)
    );

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(1)) u_dut_l1 (
        .clk       (clk),
        .reset     (reset),
        .req_valid (b_req_valid),
        .req_ready (b_req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_size  (req_size),
        .req_wdata (req_wdata),
        .rsp_valid (b_rsp_valid),
        .rsp_ready (b_rsp_ready),
        .rsp_rdata (b_rsp_rdata),
        .rsp_err   (b_rsp_err)
    );

    int  errors = 0;
    int  checks = 0;
    time acc_t;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic we, input logic [31:0] addr, input logic [1:0] size,
                        input logic [31:0] wdata);
        int n;
        n         = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_size  = size;
        req_wdata = wdata;
        while (!cur_req_ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("req_ready_wait", 32'(cur_req_ready), 32'd1);
        @(posedge clk);
        acc_t = $time;
        #1;
        req_valid = 1'b0;
        req_we    = 1'b1;
        req_addr  = 32'hFFFF_FFFF;
        req_size  = 2'b11;
        req_wdata = 32'h0BAD_0BAD;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!cur_rsp_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic take_rsp();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic xact(input string tag, input logic we, input logic [31:0] addr,
                        input logic [1:0] size, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
        int lat;
        send(we, addr, size, wdata);
        wait_rsp(lat);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_rdata"}, cur_rsp_rdata, exp_rdata);
        check({tag, "_err"}, 32'(cur_rsp_err), 32'(exp_err));
        take_rsp();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        time prev_t;
        int  lat;
        reset     = 1'b0;
        sel       = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 32'h0;
        req_size  = 2'b00;
        req_wdata = 32'h0;
        rsp_ready = 1'b0;

        #1;
        check("rst_req_ready", 32'(a_req_ready), 32'd0);
        check("rst_rsp_valid", 32'(a_rsp_valid), 32'd0);
        check("rst_rsp_rdata", a_rsp_rdata, 32'h0);
        check("rst_rsp_err", 32'(a_rsp_err), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("post_rst_req_ready", 32'(a_req_ready), 32'd1);

        // LATENCY=2 instance: word, byte-lane and sub-word accesses
        xact("st_word_10", 1'b1, 32'h10, 2'b10, 32'hDEADBEEF, 32'h0, 1'b0, 2);
        xact("ld_word_10", 1'b0, 32'h10, 2'b10, 32'h0, 32'hDEADBEEF, 1'b0, 2);
        xact("st_byte_12", 1'b1, 32'h12, 2'b00, 32'hFFFF_FFA5, 32'h0, 1'b0, 2);
        xact("ld_word_10b", 1'b0, 32'h10, 2'b10, 32'h0, 32'hDEA5BEEF, 1'b0, 2);
        xact("ld_half_12", 1'b0, 32'h12, 2'b01, 32'h0, 32'h0000DEA5, 1'b0, 2);
        xact("ld_byte_11", 1'b0, 32'h11, 2'b00, 32'h0, 32'h000000BE, 1'b0, 2);
        xact("ld_byte_13", 1'b0, 32'h13, 2'b00, 32'h0, 32'h000000DE, 1'b0, 2);

        xact("err_ld_word_13", 1'b0, 32'h13, 2'b10, 32'h0, 32'h0, 1'b1, 2);
        xact("err_st_half_11", 1'b1, 32'h11, 2'b01, 32'h0000FFFF, 32'h0, 1'b1, 2);
        xact("err_st_size3", 1'b1, 32'h10, 2'b11, 32'h11111111, 32'h0, 1'b1, 2);
        xact("err_st_oob_40", 1'b1, 32'h40, 2'b10, 32'h22222222, 32'h0, 1'b1, 2);
        xact("err_st_oob_50", 1'b1, 32'h50, 2'b10, 32'h33333333, 32'h0, 1'b1, 2);
        xact("err_ld_oob_50", 1'b0, 32'h50, 2'b10, 32'h0, 32'h0, 1'b1, 2);
        xact("ld_word_10_after_err", 1'b0, 32'h10, 2'b10, 32'h0, 32'hDEA5BEEF, 1'b0, 2);
        xact("st_last_3c", 1'b1, 32'h3C, 2'b10, 32'h0BADF00D, 32'h0, 1'b0, 2);
        xact("ld_last_3c", 1'b0, 32'h3C, 2'b10, 32'h0, 32'h0BADF00D, 1'b0, 2);
        xact("ld_half_3c", 1'b0, 32'h3C, 2'b01, 32'h0, 32'h0000F00D, 1'b0, 2);

        // Backpressure: response must stay frozen and stray requests must be ignored
        send(1'b0, 32'h10, 2'b10, 32'h0);
        wait_rsp(lat);
        check("bp_lat", 32'(lat), 32'd2);
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1;
            req_we    = 1'b1;
            req_addr  = 32'h10;
            req_size  = 2'b10;
            req_wdata = 32'h55555555;
            @(posedge clk);
            #1;
            check("bp_rsp_valid", 32'(a_rsp_valid), 32'd1);
            check("bp_rsp_rdata", a_rsp_rdata, 32'hDEA5BEEF);
            check("bp_rsp_err", 32'(a_rsp_err), 32'd0);
            check("bp_req_ready", 32'(a_req_ready), 32'd0);
        end
        req_valid = 1'b0;
        take_rsp();
        xact("ld_word_10_after_bp", 1'b0, 32'h10, 2'b10, 32'h0, 32'hDEA5BEEF, 1'b0, 2);

        // Reset during WAIT discards the pending store
        xact("st_word_20", 1'b1, 32'h20, 2'b10, 32'hCAFEF00D, 32'h0, 1'b0, 2);
        send(1'b1, 32'h20, 2'b10, 32'h12345678);
        #2;
        reset = 1'b0;
        #1;
        check("midrst_req_ready", 32'(a_req_ready), 32'd0);
        check("midrst_rsp_valid", 32'(a_rsp_valid), 32'd0);
        @(posedge clk);
        #1;
        check("midrst_hold_rsp_valid", 32'(a_rsp_valid), 32'd0);
        reset = 1'b1;
        #1;
        check("midrst_release_req_ready", 32'(a_req_ready), 32'd1);
        xact("ld_word_20_after_rst", 1'b0, 32'h20, 2'b10, 32'h0, 32'hCAFEF00D, 1'b0, 2);

        // LATENCY=1 instance, rsp_ready tied high
        sel = 1'b1;
        for (int i = 0; i < 8; i++) begin
            xact("l1_st", 1'b1, 32'(4 * i), 2'b10, 32'h0101_0101 * 32'(i + 1), 32'h0, 1'b0, 1);
        end
        prev_t = 0;
        for (int i = 0; i < 8; i++) begin
            xact("l1_ld", 1'b0, 32'(4 * i), 2'b10, 32'h0, 32'h0101_0101 * 32'(i + 1), 1'b0, 1);
            if (i > 0) begin
                check("l1_period", 32'(acc_t - prev_t), 32'd20);
            end
            prev_t = acc_t;
        end
        xact("l1_ld_byte_1d", 1'b0, 32'h1D, 2'b00, 32'h0, 32'h00000008, 1'b0, 1);
        xact("l1_err_half_1", 1'b0, 32'h1, 2'b01, 32'h0, 32'h0, 1'b1, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory target at the other end of the CPU datapath's load/store port.
- Accepts one request at a time (address, write data, size, write strobe) over a valid/ready handshake.
- Waits a programmable number of cycles, then returns a right-justified read word or a write acknowledge over a valid/ready response channel.
- Owns the word-addressed storage array. It performs byte-lane placement and alignment/range checking so the CPU-side load/store extenders only handle sign/zero extension.

Parameters:
- DEPTH, 1024, number of 32-bit words in the array (power of two, ≥4).
- LATENCY, 2, cycles from request acceptance to first rsp_valid (≥1).

Ports:
- clk  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
- req_wdata  input  32  store data, right-justified (bits [7:0] / [15:0] / [31:0]).
- rsp_valid  output  1  response present.
- rsp_ready  input  1  initiator accepts response.
- rsp_rdata  output  32  load data, right-justified, upper bits zero; 0 for stores and errors.
- rsp_err  output  1  misaligned, illegal size, or out-of-range access.

Behaviour:
- Reset values:
  - req_ready=0 while reset is low, 1 on the first cycle after release (state IDLE).
  - rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - Array contents are NOT reset.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. req_valid & req_ready captures we/addr/size/wdata into registers. If LATENCY>1, go to WAIT with count=LATENCY-1; else go to RESP.
  - WAIT: req_ready=0. Count decrements each cycle; at count==1, go to RESP.
  - RESP: rsp_valid=1. rsp_rdata and rsp_err are held stable until rsp_ready. rsp_valid & rsp_ready returns to IDLE. A new request is accepted no earlier than the following cycle. Minimum request period is LATENCY+1 cycles.
- Timing: rsp_valid first rises exactly LATENCY cycles after the acceptance edge.
- Error check (on captured request):
  - size==11 is an error.
  - size==01 with addr[0]=1 is an error.
  - size==10 with addr[1:0]≠0 is an error.
  - addr[31:2] ≥ DEPTH is an error.
  - On error: no array write, rsp_rdata=0, rsp_err=1.
- Store:
  - Byte enables are derived from size and addr[1:0].
  - wdata is shifted left by 8*addr[1:0] into the word at addr[31:2].
  - The array write happens on the clock edge entering RESP, once per request.
  - rsp_rdata=0, rsp_err=0.
- Load:
  - The word at addr[31:2] is read on the edge entering RESP.
  - It is shifted right by 8*addr[1:0] and masked to size width, with upper bits zero.
- Counter width: $clog2(LATENCY+1). No wrap: the counter only counts down from LATENCY-1.
- Reset mid-operation (WAIT or RESP): asynchronously returns to IDLE. A store not yet committed is discarded. Any response not yet handshaken is lost.
- Protocol:
  - req_valid asserted while req_ready=0 is ignored (no capture).
  - Inputs may change freely outside the acceptance cycle.
  - rsp_ready high in IDLE or WAIT has no effect.
- Read-after-write: a load issued after the store's rsp handshake observes the stored data.

Decomposition:
- Shared package dmem_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD.
  - FSM state enum.
  - function computing 4-bit byte enables from size and addr[1:0].
  - function computing the error flag.
- One sub-module, dmem_array: DEPTH×32 storage with a per-byte write enable and a synchronous read port, so the array can later be swapped for an SRAM macro.

Test Plan:
- Word store/load, LATENCY=2: store 0xDEADBEEF at 0x10, then load word at 0x10 -> rsp_valid exactly 2 cycles after acceptance, rsp_rdata=0xDEADBEEF, rsp_err=0.
- Byte lanes: after the word store above, byte store 0xA5 at 0x12, then load word 0x10 -> 0xDEA5BEEF. Load half at 0x12 -> 0x0000DEA5. Load byte at 0x11 -> 0x000000BE.
- Errors: word load at 0x13, half store at 0x11, size=11, and addr 4*DEPTH -> each gives rsp_err=1, rsp_rdata=0; a subsequent word load at 0x10 shows the array unchanged.
- Backpressure: hold rsp_ready=0 for 5 cycles -> rsp_valid, rsp_rdata and rsp_err stay constant and req_ready=0 throughout. req_valid pulses during that window are not captured.
- Reset mid-store: accept a store of 0x12345678 to 0x20, then pull reset low during WAIT -> req_ready=0 and rsp_valid=0 immediately. After release, load 0x20 -> prior contents unchanged.
- Throughput, LATENCY=1, rsp_ready tied high: 8 back-to-back loads -> one response every 2 cycles, each arriving 1 cycle after its acceptance.
